// File: rtl/regs_file_mp.sv
// regs_file_mp: multi-port register file with debug req/ack port and post-reset clear engine.
// Define REGS_BYPASS_EN to forward same-cycle pipeline write data to the read ports and debug read.
module regs_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         reg_wr_en_i,
  input  logic [ADDR_W-1:0]            reg_wr_adder_i,
  input  logic [DATA_W-1:0]            reg_wr_data_i,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_adder_i,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
  input  logic                         dbg_req_i,
  input  logic                         dbg_we_i,
  input  logic [ADDR_W-1:0]            dbg_addr_i,
  input  logic [DATA_W-1:0]            dbg_wdata_i,
  output logic                         dbg_ack_o,
  output logic [DATA_W-1:0]            dbg_rdata_o,
  output logic                         init_busy_o
);
  typedef enum logic [1:0] {INIT, RUN, ACK} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [DATA_W-1:0] rv [RD_PORTS+1];
  logic live, pipe_wr, dbg_wr, dbg_done, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  assign live    = state_q != INIT;
  assign pipe_wr = live && reg_wr_en_i && reg_wr_adder_i != '0;
  assign dbg_wr  = state_q == RUN && dbg_req_i && dbg_we_i && dbg_addr_i != '0 && !reg_wr_en_i;
  // Pipeline has priority: a debug write only completes in a cycle with no pipeline write.
  assign dbg_done = state_q == RUN && dbg_req_i && (!dbg_we_i || dbg_addr_i == '0 || !reg_wr_en_i);
  // Index RD_PORTS is the debug read path, sharing the read-port mux logic.
  for (genvar k = 0; k <= RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    if (k < RD_PORTS) begin : g_p
      assign a = rd_adder_i[k*ADDR_W +: ADDR_W];
      assign rd_data_o[k*DATA_W +: DATA_W] = rv[k];
    end else begin : g_d
      assign a = dbg_addr_i;
    end
`ifdef REGS_BYPASS_EN
    assign rv[k] = (!live || a == '0) ? '0 : (pipe_wr && a == reg_wr_adder_i) ? reg_wr_data_i : regs_q[a];
`else
    assign rv[k] = (!live || a == '0) ? '0 : regs_q[a];
`endif
  end
  always_comb begin
    wr_en       = state_q == INIT || pipe_wr || dbg_wr;
    wr_addr     = state_q == INIT ? clr_cnt_q : pipe_wr ? reg_wr_adder_i : dbg_addr_i;
    wr_data     = state_q == INIT ? '0 : pipe_wr ? reg_wr_data_i : dbg_wdata_i;
    state_d     = state_q == INIT ? (&clr_cnt_q ? RUN : INIT) : (state_q == RUN && dbg_done) ? ACK : RUN;
    clr_cnt_d   = (state_q == INIT && !(&clr_cnt_q)) ? clr_cnt_q + 1'b1 : clr_cnt_q;
    dbg_rdata_d = (dbg_done && !dbg_we_i) ? rv[RD_PORTS] : dbg_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      clr_cnt_q   <= ADDR_W'(1);
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) regs_q[wr_addr] <= wr_data;
  end
  assign dbg_ack_o   = state_q == ACK;
  assign dbg_rdata_o = dbg_rdata_q;
  assign init_busy_o = state_q == INIT;
endmodule

// File: tb/tb_regs_file_mp.sv
// tb_regs_file_mp: random and directed stimulus against a cycle-level behavioural model.
module tb_regs_file_mp;
  logic clk = 0, rst_n = 0;
  logic wr_en = 0, dbg_req = 0, dbg_we = 0;
  logic [4:0] wr_addr = 0, dbg_addr = 0;
  logic [31:0] wr_data = 0, dbg_wdata = 0, dbg_rdata;
  logic [19:0] rd_addr = 0;
  logic [127:0] rd_data;
  logic dbg_ack, busy;
  logic [31:0] mdl [32];
  int busy_left = 31;
  logic ack_m = 0;
  logic [31:0] rdata_m = 0;
  int checks = 0, errors = 0;

  regs_file_mp #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr_en_i(wr_en), .reg_wr_adder_i(wr_addr), .reg_wr_data_i(wr_data),
    .rd_adder_i(rd_addr), .rd_data_o(rd_data), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
    .init_busy_o(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_exp(input logic [4:0] a);
    if (busy_left > 0 || a == 0) return 0;
`ifdef REGS_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return mdl[a];
  endfunction

  function automatic void model_edge();
    logic served = 0;
    if (busy_left > 0) begin
      busy_left--;
      ack_m = 0;
      if (busy_left == 0) foreach (mdl[i]) mdl[i] = 0;
      return;
    end
    if (!ack_m && dbg_req) begin
      if (!dbg_we) begin
        rdata_m = rd_exp(dbg_addr);
        served = 1;
      end else if (dbg_addr == 0) served = 1;
      else if (!wr_en) begin
        mdl[dbg_addr] = dbg_wdata;
        served = 1;
      end
    end
    if (wr_en && wr_addr != 0) mdl[wr_addr] = wr_data;
    ack_m = served;
  endfunction

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) check($sformatf("rd%0d", k), rd_data[k*32 +: 32], rd_exp(rd_addr[k*5 +: 5]));
    @(posedge clk);
    model_edge();
    #1;
    check("ack", {31'b0, dbg_ack}, {31'b0, ack_m});
    check("dbg_rdata", dbg_rdata, rdata_m);
    check("busy", {31'b0, busy}, {31'b0, busy_left > 0});
    if (ack_m) dbg_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    busy_left = 31;
    ack_m = 0;
    rdata_m = 0;
    dbg_req = 0;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_ack", {31'b0, dbg_ack}, 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_rd", rd_data[31:0], 32'd0);
    #1 rst_n = 1;
  endtask

  task automatic set_ports(input logic [4:0] a);
    rd_addr = {a, a, a, a};
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 31; i++) begin
      wr_en = 1; wr_addr = 5'(i + 1); wr_data = $urandom; rd_addr = 20'($urandom);
      step();
    end
    wr_en = 1; wr_addr = 5; wr_data = 32'h55; step();
    wr_en = 0; set_ports(5); step();
    do_reset();
    for (int i = 0; i < 31; i++) step();
    set_ports(5); step();
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; set_ports(7); step();
    wr_en = 0; step();
    wr_en = 1; wr_addr = 0; wr_data = 32'h1; set_ports(0); step();
    wr_en = 0; step();
    wr_en = 1; wr_addr = 9; wr_data = 32'h99; set_ports(3);
    dbg_req = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'h12345678;
    n = 0;
    while (n < 10) begin
      if (n == 3) wr_en = 0;
      step();
      n++;
      if (dbg_ack) break;
    end
    check("dbg_wr_latency", n, 4);
    rd_addr = {5'd9, 5'd3, 5'd9, 5'd3}; step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 9; step(); step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 0; step(); step();
    wr_en = 1; wr_addr = 4; wr_data = 32'hA5A5A5A5; set_ports(4); step();
    wr_en = 0; step();
    wr_en = 1; wr_addr = 2; wr_data = 32'h22; dbg_req = 1; dbg_we = 1; dbg_addr = 2; dbg_wdata = 32'h77;
    step();
    do_reset();
    wr_en = 0;
    for (int i = 0; i < 9; i++) step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 7;
    do_reset();
    for (int i = 0; i < 32; i++) step();
    for (int i = 0; i < 600; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_addr = 20'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[4:0] = wr_addr;
      if (!dbg_req && !ack_m && $urandom_range(0, 3) == 0) begin
        dbg_req = 1;
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom);
        dbg_wdata = $urandom;
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
